// File: rtl/heichips25_pudding.sv
// Serial-load configuration register tile.
// A bit-serial daisychain feeds a parallel state register; transfers copy
// contents between the two in either direction. The top byte of each register
// is exported on the tile outputs.
module heichips25_pudding #(
    parameter int unsigned WIDTH = 128  // must be at least 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    inout  wire        i_in,
    inout  wire        i_out
);

    logic datum;
    logic shift;
    logic transfer;
    logic dir;

    logic [WIDTH-1:0] chain_q, chain_d;
    logic [WIDTH-1:0] state_q, state_d;

    // stateen (ui_in[4]), ui_in[7:5], uio_in, ena and the analog pins are
    // deliberately inert; fold them into one sink so they are not flagged.
    logic unused_inputs;
    assign unused_inputs = ^{ui_in[7:4], uio_in, ena, i_in, i_out};

    assign datum    = ui_in[0];
    assign shift    = ui_in[1];
    assign transfer = ui_in[2];
    assign dir      = ui_in[3];

    // Next-state: transfer beats shift; dir=1 captures chain into state.
    always_comb begin
        chain_d = chain_q;
        state_d = state_q;
        if (transfer) begin
            if (dir) begin
                state_d = chain_q;
            end else begin
                chain_d = state_q;
            end
        end else if (shift) begin
            chain_d = {chain_q[WIDTH-2:0], datum};
        end
    end

    // Register update with synchronous reset overriding any command.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
            state_q <= '0;
        end else begin
            chain_q <= chain_d;
            state_q <= state_d;
        end
    end

    assign uo_out  = chain_q[WIDTH-1:WIDTH-8];
    assign uio_out = state_q[WIDTH-1:WIDTH-8];
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_heichips25_pudding.sv
// Directed + random bench for heichips25_pudding with a queued scoreboard.
module tb_heichips25_pudding;

    localparam int unsigned W = 128;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;
    wire        i_in_w;
    wire        i_out_w;

    heichips25_pudding #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .i_in   (i_in_w),
        .i_out  (i_out_w)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] uo;
        logic [7:0] uio;
        logic [7:0] oe;
    } exp_t;

    exp_t       sb_q[$];
    logic [W-1:0] chain_m;
    logic [W-1:0] state_m;
    int         n_assert = 0;
    int         n_fail   = 0;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the reference model, push expectations,
    // then pop and compare after the edge.
    task automatic step(input logic r, input logic [7:0] ui, input logic [7:0] uio,
                        input logic en);
        exp_t e;
        rst    = r;
        ui_in  = ui;
        uio_in = uio;
        ena    = en;
        if (r) begin
            chain_m = '0;
            state_m = '0;
        end else if (ui[2]) begin
            if (ui[3]) state_m = chain_m;
            else       chain_m = state_m;
        end else if (ui[1]) begin
            chain_m = {chain_m[W-2:0], ui[0]};
        end
        sb_q.push_back('{uo: chain_m[W-1:W-8], uio: state_m[W-1:W-8], oe: 8'hFF});
        @(posedge clk);
        #1;
        n_assert++;
        assert (sb_q.size() != 0)
        else begin
            n_fail++;
            $error("FAIL sb_empty observed=%0d expected=nonzero", sb_q.size());
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk8("uo_out", uo_out, e.uo);
            chk8("uio_out", uio_out, e.uio);
            chk8("uio_oe", uio_oe, e.oe);
        end
    endtask

    initial begin
        logic [127:0] payload;
        logic [7:0]   ui;
        payload = 128'h0123456789abcdeffedcba9876543210;
        chain_m = '0;
        state_m = '0;
        rst = 1'b1; ui_in = 8'h00; uio_in = 8'h00; ena = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with random commands
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 8'($urandom), 1'b1);
        chk8("reset_uo", uo_out, 8'h00);
        chk8("reset_uio", uio_out, 8'h00);

        // Serial load LSB first
        for (int i = 0; i < 128; i++) step(1'b0, {6'b0, 1'b1, payload[i]}, 8'h00, 1'b1);
        chk8("load_uo", uo_out, 8'h08);
        chk8("load_uio", uio_out, 8'h00);

        // Capture into state
        step(1'b0, 8'h0C, 8'h00, 1'b1);
        chk8("cap_uio", uio_out, 8'h08);
        chk8("cap_uo", uo_out, 8'h08);

        // Disturb the chain, then restore from state
        for (int i = 0; i < 10; i++) step(1'b0, {6'b0, 1'b1, 1'($urandom)}, 8'h00, 1'b1);
        step(1'b0, 8'h04, 8'h00, 1'b1);
        chk8("restore_uo", uo_out, 8'h08);

        // Transfer beats shift in the same cycle
        step(1'b0, 8'h0F, 8'h00, 1'b1);
        chk8("prio_uo", uo_out, 8'h08);
        chk8("prio_uio", uio_out, 8'h08);

        // Idle with irrelevant inputs toggling
        for (int i = 0; i < 20; i++) begin
            ui = 8'($urandom) & 8'hF9;
            step(1'b0, ui, 8'($urandom), 1'($urandom));
        end
        chk8("hold_uo", uo_out, 8'h08);
        chk8("hold_uio", uio_out, 8'h08);

        // Random regression
        for (int i = 0; i < 500; i++) begin
            ui = 8'($urandom);
            case ($urandom_range(0, 3))
                0: ui[2:1] = 2'b00;
                1: ui[2:1] = 2'b01;
                2: ui[3:2] = 2'b11;
                default: ui[3:2] = 2'b01;
            endcase
            step(1'b0, ui, 8'($urandom), 1'($urandom));
        end

        // Reset mid-sequence with commands asserted
        step(1'b0, 8'h03, 8'h00, 1'b1);
        step(1'b0, 8'h0C, 8'h00, 1'b1);
        step(1'b1, 8'h0F, 8'h00, 1'b1);
        chk8("midrst_uo", uo_out, 8'h00);
        chk8("midrst_uio", uio_out, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/heichips25_pudding.md
Name: heichips25_pudding

Overview:
- Serial-load configuration register block in a tiny-tapeout-style user tile.
- A WIDTH-bit shift register ("daisychain") is loaded bit-serially from a dedicated input.
- A parallel "state" register of the same width exchanges contents with the daisychain in either direction on a transfer command.
- The top byte of each register is exported on the tile outputs for observation and use.

Parameters:
- WIDTH, 128, length of both the daisychain and the state register; must be ≥ 8.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- ui_in  input  8  command/data inputs:
  - [0] datum
  - [1] shift
  - [2] transfer
  - [3] dir
  - [4] stateen
  - [7:5] unused
- uo_out  output  8  daisychain[WIDTH-1:WIDTH-8].
- uio_in  input  8  unused, ignored.
- uio_out  output  8  state[WIDTH-1:WIDTH-8].
- uio_oe  output  8  constant 8'hFF (all bidirectional pins driven as outputs).
- ena  input  1  tile enable; ignored, logic always active.
- i_in  inout  1  analog pass-through pin; not driven by this block (high-Z).
- i_out  inout  1  analog pass-through pin; not driven by this block (high-Z).

Behaviour:
- Registers: daisychain[WIDTH-1:0], state[WIDTH-1:0]. No other sequential state.
- Reset: on a rising clk with rst=1, daisychain and state are cleared to all zeros.
  - Therefore uo_out=00 and uio_out=00 from the edge after rst is sampled high.
  - Reset overrides shift and transfer in the same cycle.
  - Reset mid-sequence discards all loaded bits.
- Per rising edge with rst=0, evaluated in priority order:
  1. transfer=1, dir=1: state <= daisychain; daisychain unchanged.
  2. transfer=1, dir=0: daisychain <= state; state unchanged.
  3. transfer=0, shift=1: daisychain <= {daisychain[WIDTH-2:0], datum}; state unchanged.
  4. Otherwise: both registers hold.
- transfer has strict priority over shift; shift is ignored when both are asserted.
- datum is sampled at the same edge as shift. The first bit shifted ends in bit WIDTH-1 after WIDTH shifts, so an LSB-first payload appears bit-reversed.
- Bits shifted out of daisychain[WIDTH-1] are discarded; no serial output.
- Latency: uo_out/uio_out are combinational slices of the registers and reflect an update immediately after the edge that performs it (one-cycle command-to-output).
- Level-sensitive commands: each cycle a command is held high performs one operation. Repeated transfers are idempotent; repeated shifts shift repeatedly.
- stateen, ui_in[7:5], uio_in and ena have no effect on any register or output.
- uio_oe is 8'hFF at all times, including during reset.
- i_in, i_out are never driven (high-Z).
- No X propagation: with known inputs, outputs are always known after the first reset.

Test Plan:
- Reset: assert rst for 3 cycles with random ui_in -> uo_out=00, uio_out=00, uio_oe=FF; no change while rst held.
- Serial load: shift in 0x0123456789abcdeffedcba9876543210 LSB first (128 shifts) -> daisychain = bit-reversed payload, uo_out=08, uio_out=00.
- Transfer dir=1 -> uio_out=08, daisychain unchanged. Then 10 random shifts, then transfer dir=0 -> daisychain restored, uo_out=08.
- Priority: shift=1, transfer=1, dir=1, datum=1 in one cycle -> only state<=daisychain; daisychain does not shift.
- Hold/ignore: 20 cycles with shift=transfer=0, toggling stateen, uio_in, ena, ui_in[7:5] -> uo_out and uio_out unchanged.
- Random regression: 500 cycles of random shift/transfer/dir/idle against a cycle-accurate reference model -> uo_out, uio_out, uio_oe match every cycle.
